// File: rtl/mult_unit_if.sv
// Multiplier request/result bundle.
// master: the side that issues multiplies and reads HI/LO (decode/execute).
// slave : the multiplier itself.
//   start_mult  one-cycle request to begin a multiply
//   mult_sign   1 = signed (mult), 0 = unsigned (multu)
//   a, b        operands, sampled only when a request is accepted
//   hi, lo      upper/lower halves of the last completed product
//   busy        a multiply is in flight
//   done        one-cycle pulse: hi/lo were just updated
interface mult_unit_if #(
    parameter int WIDTH = 32
);
    logic             start_mult;
    logic             mult_sign;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start_mult, mult_sign, a, b,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start_mult, mult_sign, a, b,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mult_unit.sv
// Multi-cycle WIDTH x WIDTH -> 2*WIDTH integer multiplier with HI/LO registers.
// Radix-2 shift-add on operand magnitudes; the sign is reapplied at the end.
// A start accepted at edge E0 updates hi/lo and pulses done at E0+WIDTH+1.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (aborts any multiply, clears hi/lo)
//   bus      mult_unit_if slave: start_mult, mult_sign, a, b in; hi, lo, busy, done out
module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    mult_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] DW_ONE   = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;   // multiplicand, pre-shifted by count
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 neg_q, neg_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Magnitude of a two's-complement value; -2^(WIDTH-1) maps to 2^(WIDTH-1),
    // which is still representable as an unsigned WIDTH-bit number.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (v[WIDTH-1]) begin
            r = ~v + W_ONE;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Next-state and datapath logic for the IDLE/CALC/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_mult) begin
                    if (bus.mult_sign) begin
                        mcand_d  = {{WIDTH{1'b0}}, magnitude(bus.a)};
                        mplier_d = magnitude(bus.b);
                        neg_d    = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                    end else begin
                        mcand_d  = {{WIDTH{1'b0}}, bus.a};
                        mplier_d = bus.b;
                        neg_d    = 1'b0;
                    end
                    acc_d   = {(2*WIDTH){1'b0}};
                    count_d = {CW{1'b0}};
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_ONE;
                if (count_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                if (neg_q) begin
                    {hi_d, lo_d} = ~acc_q + DW_ONE;
                end else begin
                    {hi_d, lo_d} = acc_q;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // busy is registered, so it tracks the state being entered.
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            acc_q    <= {(2*WIDTH){1'b0}};
            mcand_q  <= {(2*WIDTH){1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            count_q  <= {CW{1'b0}};
            neg_q    <= 1'b0;
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_mult_unit.sv
module tb_mult_unit;
    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mult_unit_if #(.WIDTH(W)) bus ();

    mult_unit #(.WIDTH(W)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] last_prod;   // model of the current {hi,lo}

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference product straight from arithmetic on the full-width values.
    function automatic logic [63:0] ref_prod(input logic sgn, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        if (sgn) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            return sx * sy;
        end else begin
            return {32'd0, x} * {32'd0, y};
        end
    endfunction

    // Issue one request; returns just after the accepting edge E0.
    task automatic start_op(input logic sgn, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        bus.start_mult = 1'b1;
        bus.mult_sign  = sgn;
        bus.a          = x;
        bus.b          = y;
        @(negedge clk);
        bus.start_mult = 1'b0;
        bus.a          = $urandom;   // must not affect the in-flight operation
        bus.b          = $urandom;
        bus.mult_sign  = ~sgn;
    endtask

    // Follow an operation from E0 to completion. k counts edges after E0.
    // ign1/ign2: cycles at which a 9*9 start is pulsed while busy.
    // chain: issue a new start in the done cycle.
    task automatic wait_done(input string tag, input logic [63:0] exp,
                             input int ign1, input int ign2,
                             input logic chain, input logic csgn,
                             input logic [31:0] ca, input logic [31:0] cb);
        int lat;
        lat = -1;
        for (int k = 0; k <= LAT + 4; k++) begin
            bus.start_mult = 1'b0;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (k == 0)  check_val({tag, ".busy_start"}, 64'(bus.busy), 64'd1);
            if (k == 16 || k == LAT - 1) begin
                check_val({tag, ".busy_mid"}, 64'(bus.busy), 64'd1);
                check_val({tag, ".hold"}, {bus.hi, bus.lo}, last_prod);
            end
            if (k == ign1 || k == ign2) begin
                bus.start_mult = 1'b1;
                bus.mult_sign  = 1'b0;
                bus.a          = 32'd9;
                bus.b          = 32'd9;
            end
            @(negedge clk);
        end
        check_val({tag, ".latency"}, 64'(lat), 64'(LAT));
        check_val({tag, ".result"}, {bus.hi, bus.lo}, exp);
        check_val({tag, ".busy_done"}, 64'(bus.busy), 64'd0);
        last_prod = exp;
        if (chain) begin
            bus.start_mult = 1'b1;
            bus.mult_sign  = csgn;
            bus.a          = ca;
            bus.b          = cb;
            @(negedge clk);
            bus.start_mult = 1'b0;
        end else begin
            @(negedge clk);
            check_val({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
        end
    endtask

    task automatic run_op(input string tag, input logic sgn, input logic [31:0] x, input logic [31:0] y);
        start_op(sgn, x, y);
        wait_done(tag, ref_prod(sgn, x, y), -1, -1, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] edge_vals [5];
        logic [31:0] x, y;
        logic        s;
        edge_vals = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

        reset_n        = 1'b0;
        bus.start_mult = 1'b0;
        bus.mult_sign  = 1'b0;
        bus.a          = 32'd0;
        bus.b          = 32'd0;
        last_prod      = 64'd0;
        repeat (3) @(negedge clk);
        check_val("reset.hilo", {bus.hi, bus.lo}, 64'd0);
        check_val("reset.busy", 64'(bus.busy), 64'd0);
        check_val("reset.done", 64'(bus.done), 64'd0);
        reset_n = 1'b1;

        run_op("multu_7x6", 1'b0, 32'd7, 32'd6);
        check_val("multu_7x6.const", {bus.hi, bus.lo}, 64'h0000_0000_0000_002A);
        run_op("multu_ff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_val("multu_ff.const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_m1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_val("mult_m1.const", {bus.hi, bus.lo}, 64'h0000_0000_0000_0001);
        run_op("mult_3xm5", 1'b1, 32'd3, 32'hFFFF_FFFB);
        check_val("mult_3xm5.const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("mult_min", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check_val("mult_min.const", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

        // Starts while busy (sampled at E0+10 and E0+33) are ignored.
        start_op(1'b0, 32'd5, 32'd5);
        wait_done("ignore_busy", 64'd25, 9, LAT - 1, 1'b0, 1'b0, 32'd0, 32'd0);
        check_val("ignore_busy.idle", 64'(bus.busy), 64'd0);

        // Back-to-back: new start in the done cycle.
        start_op(1'b0, 32'd2, 32'd3);
        wait_done("b2b_first", 64'd6, -1, -1, 1'b1, 1'b0, 32'd4, 32'd4);
        wait_done("b2b_second", 64'd16, -1, -1, 1'b0, 1'b0, 32'd0, 32'd0);

        // Asynchronous reset mid-operation.
        start_op(1'b1, 32'd100, 32'd100);
        repeat (14) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        last_prod = 64'd0;
        check_val("async_rst.hilo", {bus.hi, bus.lo}, 64'd0);
        check_val("async_rst.busy", 64'(bus.busy), 64'd0);
        check_val("async_rst.done", 64'(bus.done), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op("after_rst", 1'b0, 32'd2, 32'd2);

        // Randomized operations, biased toward boundary operands.
        for (int i = 0; i < 16; i++) begin
            s = 1'($urandom_range(0, 1));
            x = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
            run_op($sformatf("rand%0d", i), s, x, y);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Multi-cycle 32x32 -> 64-bit integer multiplier with HI/LO result registers.
- Sits directly downstream of the decode controller and consumes its start_mult and mult_sign outputs, which are driven by mult and multu.
- Supplies the hi and lo values selected by the execute-stage output mux for mfhi and mflo.
- Provides a busy flag so the pipeline stalls mfhi, mflo and back-to-back mult while a product is in flight.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start_mult  input  1  one-cycle request from the controller to begin a multiply.
- mult_sign  input  1  1 = signed (mult), 0 = unsigned (multu); sampled with start_mult.
- a  input  WIDTH  rs operand; sampled only on an accepted start.
- b  input  WIDTH  rt operand; sampled only on an accepted start.
- hi  output  WIDTH  upper half of the last completed product.
- lo  output  WIDTH  lower half of the last completed product.
- busy  output  1  high while a multiply is in progress (state != IDLE).
- done  output  1  registered one-cycle pulse: hi/lo have just been updated.

Behaviour:
- Reset, asynchronous on reset_n low:
  - state = IDLE; hi = 0; lo = 0; done = 0; busy = 0.
  - Internal accumulator, multiplicand, multiplier, counter and negate flag are all cleared.
- Reset mid-operation aborts the multiply. hi/lo read 0, not the old product.
- FSM states: IDLE, CALC, DONE.
- IDLE, with start_mult = 1 at a clock edge:
  - Signed mode: latch |a| and |b| as WIDTH-bit unsigned magnitudes. Set neg = a[MSB] XOR b[MSB].
  - Unsigned mode: latch a and b unchanged; neg = 0.
  - Clear the 2*WIDTH accumulator, set count = 0, go to CALC.
  - The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which fits unsigned WIDTH bits; no overflow special case is needed.
- CALC, one radix-2 shift-add step per cycle:
  - If the multiplier LSB is 1, add the multiplicand, shifted left by count, into the accumulator. Shift the multiplier right by 1.
  - count increments each step. When count == WIDTH-1, go to DONE.
  - Exactly WIDTH CALC cycles.
- DONE:
  - On the next edge, {hi,lo} <= neg ? two's-complement negation of the accumulator : accumulator, computed modulo 2^(2*WIDTH).
  - On the same edge done is set to 1 (high for exactly one cycle) and state returns to IDLE.
- Latency: for a start accepted at edge E0, hi/lo update and done rises at edge E0+WIDTH+1, i.e. E0+33 for WIDTH=32. busy is high in the cycles between E0 and E0+WIDTH+1 and low from E0+WIDTH+1.
- hi/lo hold their previous values for the whole operation. They change only at the DONE edge or on reset.
- start_mult while busy = 1 (CALC or DONE) is ignored. The operands and mode of the in-flight operation are unaffected, and no request is queued.
- start_mult in the same cycle that done = 1 is legal, because state is IDLE: the new operation is accepted and hi/lo keep the just-written result until its own DONE edge.
- Changes to a, b and mult_sign after acceptance have no effect.
- The accumulator is 2*WIDTH bits. Unsigned products never overflow it.

Test Plan:
- Reset, then multu a=7, b=6 -> busy high 33 cycles; done pulses once at start edge+33; hi=0x00000000, lo=0x0000002A.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then mult with the same operands (-1*-1) -> hi=0x00000000, lo=0x00000001.
- mult a=3, b=0xFFFFFFFB (-5) -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then mult a=0x80000000, b=0xFFFFFFFF -> hi=0x00000000, lo=0x80000000.
- Start multu 5*5, then pulse start_mult with a=9, b=9 at cycles 10 and 33 after the start (busy high) -> ignored; result hi=0, lo=25; hi/lo remain at the prior values until the DONE edge.
- Start multu 2*3; assert start_mult with a=4, b=4 in the cycle where done=1 -> lo=6 visible, then 33 cycles later lo=16; busy stays low for only the done cycle.
- Start mult 100*100, drop reset_n asynchronously mid-cycle at cycle 15 -> hi, lo, busy and done go to 0 immediately. After release, a new multu 2*2 completes normally with lo=4.
